// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin ring arbiter.
// Vectors are [0:N-1]: index 0 is the leftmost bit.
interface ring_rr_arbiter_if #(
  parameter int unsigned N = 8
);
  logic [0:N-1] req;
  logic [0:N-1] grant;
  logic         grant_valid;
  logic [0:N-1] token;
  logic         expired;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  token,
    input  expired
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output token,
    output expired
  );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot priority token and a bounded grant length.
// Every grant ends with a one-cycle hand-over gap before the next winner.
module ring_rr_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              init,
  ring_rr_arbiter_if.slave  bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [0:N-1]  grant_q, grant_d;
  logic [0:N-1]  token_q, token_d;
  logic          grant_valid_q;
  logic          expired_q, expired_d;
  logic [HW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] tok_idx, own_idx, win_idx, next_idx;
  logic [IW:0]   scan;
  logic          found;
  logic          release_now;

  always_comb begin
    tok_idx = '0;
    own_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = IW'(i);
      if (grant_q[i]) own_idx = IW'(i);
    end

    // First requester at or after the token, wrapping past N-1.
    found   = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, tok_idx} + (IW + 1)'(k);
      if (scan >= (IW + 1)'(N)) scan = scan - (IW + 1)'(N);
      if (!found && bus.req[scan[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = scan[IW-1:0];
      end
    end

    next_idx = (own_idx == IW'(N - 1)) ? '0 : own_idx + 1'b1;

    state_d     = state_q;
    grant_d     = grant_q;
    token_d     = token_q;
    cnt_d       = cnt_q;
    expired_d   = 1'b0;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          cnt_d            = HW'(1);
          state_d          = GRANT;
        end
      end
      GRANT: begin
        // A dropped request wins over preemption when both land on one edge.
        if (!bus.req[own_idx]) begin
          release_now = 1'b1;
        end else if (cnt_q < HW'(MAX_HOLD)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          release_now = 1'b1;
          expired_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_now) begin
      grant_d           = '0;
      token_d           = '0;
      token_d[next_idx] = 1'b1;
      cnt_d             = '0;
      state_d           = IDLE;
    end
  end

  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      token_q       <= {1'b1, {(N - 1){1'b0}}};
      grant_valid_q <= 1'b0;
      expired_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      token_q       <= token_d;
      grant_valid_q <= |grant_d;
      expired_q     <= expired_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.token       = token_q;
  assign bus.expired     = expired_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Randomized and directed bench for ring_rr_arbiter against a cycle-level model.
module tb_ring_rr_arbiter;
  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic clock;
  logic init;

  ring_rr_arbiter_if #(.N(N)) bus ();

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock (clock),
    .init  (init),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: which requester (if any) owns the resource and for how long.
  bit m_busy;
  int m_owner;
  int m_held;
  int m_tok;
  bit m_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [0:N-1] onehot(input int i);
    logic [0:N-1] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_held  = 0;
    m_tok   = 0;
    m_exp   = 1'b0;
  endtask

  task automatic model_edge(input logic [0:N-1] r);
    m_exp = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_tok + k) % N]) begin
          m_owner = (m_tok + k) % N;
          m_busy  = 1'b1;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 1'b0;
      m_tok  = (m_owner + 1) % N;
    end else if (m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      m_busy = 1'b0;
      m_tok  = (m_owner + 1) % N;
      m_exp  = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [0:N-1] g;
    g = m_busy ? onehot(m_owner) : '0;
    check_eq({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check_eq({tag, ".valid"}, 32'(bus.grant_valid), 32'(m_busy));
    check_eq({tag, ".token"}, 32'(bus.token), 32'(onehot(m_tok)));
    check_eq({tag, ".expired"}, 32'(bus.expired), 32'(m_exp));
  endtask

  task automatic step(input string tag, input logic [0:N-1] r);
    bus.req = r;
    @(posedge clock);
    model_edge(r);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset away from any clock edge.
  task automatic do_reset();
    #2;
    init = 1'b1;
    #1;
    model_reset();
    compare_all("reset");
    #1;
    init = 1'b0;
  endtask

  logic [0:N-1] r;
  int n_exp;

  initial begin
    init    = 1'b1;
    bus.req = '0;
    model_reset();
    #3;
    compare_all("por");
    init = 1'b0;

    // Async reset while requester 3 holds the grant.
    step("t1a", onehot(3));
    step("t1b", onehot(3));
    check_eq("t1.pre_grant", 32'(bus.grant), 32'(8'b0001_0000));
    #2;
    init = 1'b1;
    #1;
    check_eq("t1.grant", 32'(bus.grant), 32'(8'b0000_0000));
    check_eq("t1.token", 32'(bus.token), 32'(8'b1000_0000));
    check_eq("t1.expired", 32'(bus.expired), 32'(1'b0));
    check_eq("t1.valid", 32'(bus.grant_valid), 32'(1'b0));
    #1;
    init = 1'b0;
    model_reset();

    // Short grant, release, hand-over gap.
    do_reset();
    step("t2a", onehot(3));
    step("t2b", onehot(3));
    step("t2c", '0);
    check_eq("t2.token", 32'(bus.token), 32'(8'b0000_1000));
    step("t2d", '0);

    // All requesting: 9 preempted grants of 4 cycles with one gap each.
    do_reset();
    n_exp = 0;
    for (int c = 0; c < 45; c++) begin
      step("t3", '1);
      if (bus.expired) n_exp++;
    end
    check_eq("t3.expired_count", 32'(n_exp), 32'(9));

    // Token at 5 with requests {2,6}.
    do_reset();
    step("t4a", onehot(4));
    step("t4b", '0);
    step("t4c", onehot(2) | onehot(6));
    check_eq("t4.first", 32'(bus.grant), 32'(8'b0000_0010));
    step("t4d", onehot(2));
    check_eq("t4.token", 32'(bus.token), 32'(8'b0000_0001));
    step("t4e", onehot(2));
    check_eq("t4.second", 32'(bus.grant), 32'(8'b0010_0000));
    step("t4f", '0);

    // Owner 7 releases: token wraps to 0.
    step("t5a", onehot(7));
    step("t5b", onehot(0));
    check_eq("t5.token", 32'(bus.token), 32'(8'b1000_0000));
    step("t5c", onehot(0));
    check_eq("t5.grant", 32'(bus.grant), 32'(8'b1000_0000));
    step("t5d", '0);

    // Request drops exactly when the hold limit is reached.
    do_reset();
    for (int c = 0; c < 4; c++) step("t6a", onehot(1));
    step("t6b", '0);
    check_eq("t6.expired", 32'(bus.expired), 32'(1'b0));
    check_eq("t6.token", 32'(bus.token), 32'(8'b0010_0000));

    // Random traffic with sticky request patterns.
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       r = onehot($urandom_range(0, N - 1));
          1:       r = N'($urandom);
          default: r = '0;
        endcase
      end
      step("rand", r);
      check_eq("rand.token_onehot", 32'($onehot(bus.token)), 32'(1));
      if (c == 200) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
